// File: rtl/mul_issue_arbiter.sv
// mul_issue_arbiter: shares one two-stage pipelined 32x32 multiplier between
// the two issue slots. It arbitrates with a round-robin pointer (or a fixed
// priority), drives the multiplier operands and per-stage holds, shadows each
// operation's id/tag through both stages, and returns the result on a single
// valid/ready response channel with back-pressure and flush support.

package mul_issue_pkg;

  // Multiply op encodings shared with the decoder.
  typedef enum logic [1:0] {
    MUL_OP_MUL   = 2'd0,  // low 32 bits of the product
    MUL_OP_MULH  = 2'd1,  // high 32 bits, signed x signed
    MUL_OP_MULHU = 2'd2   // high 32 bits, unsigned x unsigned
  } mul_op_e;

endpackage : mul_issue_pkg

module mul_issue_arbiter
  import mul_issue_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter bit RR_EN = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,

  // Request side, one slot per issue lane
  input  logic [1:0]                  req_valid_i,
  output logic [1:0]                  req_ready_o,
  input  logic [1:0][1:0]             req_op_i,
  input  logic [1:0][31:0]            req_r0_i,
  input  logic [1:0][31:0]            req_r1_i,
  input  logic [1:0][TAG_W-1:0]       req_tag_i,

  input  logic                        flush_i,

  // Multiplier interface
  output logic [1:0]                  mul_op_o,
  output logic [31:0]                 mul_r0_o,
  output logic [31:0]                 mul_r1_o,
  output logic                        mul_ex_stall_o,
  output logic                        mul_m1_stall_o,
  output logic                        mul_m2_stall_o,
  input  logic [31:0]                 mul_result_i,

  // Response channel
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic                        rsp_id_o,
  output logic [TAG_W-1:0]            rsp_tag_o,
  output logic [31:0]                 rsp_data_o
);

  // Shadow of multiplier stage 1
  logic             s1_v;
  logic             s1_id;
  logic [TAG_W-1:0] s1_tag;

  // Shadow of multiplier stage 2 (the result register)
  logic             s2_v;
  logic             s2_id;
  logic [TAG_W-1:0] s2_tag;

  // Requester that wins the next contested slot
  logic             rr_ptr;

  logic             winner;
  logic             m1_stall;
  logic             m2_stall;
  logic             can_issue;
  logic             accepted;

  // Stage holds: the result register holds while its response is refused;
  // stage 1 only holds if it has something to hold, so an empty stage 1
  // keeps accepting even while the result register is stuck.
  assign m2_stall  = s2_v & ~rsp_ready_i;
  assign m1_stall  = s1_v & m2_stall;

  // rst_n is folded in so nothing looks grantable while the block is in reset.
  assign can_issue = rst_n & ~m1_stall & ~flush_i;

  // Pick the winner: a lone requester wins outright; a contested slot goes to
  // rr_ptr under round-robin, otherwise to requester 0.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default on entry;
    // a path that leaves one unassigned would infer a latch.
    winner = 1'b0;
    if (&req_valid_i) begin
      winner = RR_EN ? rr_ptr : 1'b0;
    end else if (req_valid_i[1]) begin
      winner = 1'b1;
    end
  end

  assign accepted = can_issue & req_valid_i[winner];

  // Only the winner sees ready; the loser retries next cycle.
  always_comb begin
    req_ready_o         = '0;
    req_ready_o[winner] = can_issue;
  end

  // Operand mux towards the multiplier. With no valid request this still
  // forwards requester 0, which is harmless because s1_v is not set.
  always_comb begin
    mul_op_o = '0;
    mul_r0_o = '0;
    mul_r1_o = '0;
    if (rst_n) begin
      mul_op_o = req_op_i[winner];
      mul_r0_o = req_r0_i[winner];
      mul_r1_o = req_r1_i[winner];
    end
  end

  assign mul_ex_stall_o = 1'b0;
  assign mul_m1_stall_o = m1_stall;
  assign mul_m2_stall_o = m2_stall;

  // Stage-1 tracking: follows the multiplier's stage-1 enable; a flush kills
  // whatever is there even if the stage is currently held.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of order.
    if (!rst_n) begin
      // NOTE: these are a handful of control flops, not a memory, so all of
      // them (including id/tag) are reset to give clean outputs in reset.
      s1_v   <= 1'b0;
      s1_id  <= 1'b0;
      s1_tag <= '0;
    end else begin
      if (flush_i) begin
        s1_v <= 1'b0;
      end else if (!m1_stall) begin
        s1_v <= accepted;
      end
      if (!m1_stall) begin
        s1_id  <= winner;
        s1_tag <= req_tag_i[winner];
      end
    end
  end

  // Stage-2 tracking: advances from stage 1 whenever the result register is
  // free or its response is taken this cycle, giving back-to-back responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v   <= 1'b0;
      s2_id  <= 1'b0;
      s2_tag <= '0;
    end else begin
      if (flush_i) begin
        s2_v <= 1'b0;
      end else if (!m2_stall) begin
        s2_v <= s1_v;
      end
      if (!m2_stall) begin
        s2_id  <= s1_id;
        s2_tag <= s1_tag;
      end
    end
  end

  // Round-robin pointer: after a transfer the other requester gets priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (accepted) begin
      rr_ptr <= ~winner;
    end
  end

  assign rsp_valid_o = s2_v;
  assign rsp_id_o    = s2_id;
  assign rsp_tag_o   = s2_tag;
  assign rsp_data_o  = mul_result_i;

  // Structural invariants of the grant and hold logic.
  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready_o));

  a_no_accept_on_flush : assert property (@(posedge clk) disable iff (!rst_n)
    flush_i |-> ((req_valid_i & req_ready_o) == 2'b00));

  a_legal_op : assert property (@(posedge clk) disable iff (!rst_n)
    accepted |-> (mul_op_o inside {MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHU}));

  a_result_held : assert property (@(posedge clk) disable iff (!rst_n)
    (s2_v && !rsp_ready_i && !flush_i) |=> (s2_v && $stable(s2_id) && $stable(s2_tag)));

endmodule : mul_issue_arbiter
